data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory port: accepts `dm_write`, `dm_addr` and `dm_data_in`, and returns `dm_data_out` one cycle later.
- Contains a word-addressed RAM and a small MMIO window: a GPIO output register, a free-running cycle counter, and a sticky error/status register.
- Sits beside the CPU in the top level, wired straight to its `dm_*` ports.

---
 rtl/data_mem_responder_pkg.sv | 42 ++++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_dm_ram.sv | 30 +++
 rtl/data_mem_responder.sv | 106 ++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// status bit positions, region decode type and the address decode helper.
package data_mem_responder_pkg;

  localparam int DATA_WIDTH = 32;

  // Byte offsets of the MMIO registers relative to the window base
  localparam logic [31:0] MMIO_OFF_GPIO = 32'h0000_0000;
  localparam logic [31:0] MMIO_OFF_CNT  = 32'h0000_0004;
  localparam logic [31:0] MMIO_OFF_STAT = 32'h0000_0008;

  // Bit positions inside the sticky status register
  localparam int ERR_MISALIGNED = 0;
  localparam int ERR_UNMAPPED   = 1;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_GPIO,
    REG_CNT,
    REG_STAT,
    REG_UNMAPPED
  } region_e;

  // Classify a byte address; alignment is judged separately by the caller
  function automatic region_e decodeRegion(input logic [31:0] addr,
                                           input logic [31:0] ramBytes,
                                           input logic [31:0] mmioBase);
    region_e r;
    r = REG_UNMAPPED;
    if (addr < ramBytes) begin
      r = REG_RAM;
    end else if (addr == mmioBase + MMIO_OFF_GPIO) begin
      r = REG_GPIO;
    end else if (addr == mmioBase + MMIO_OFF_CNT) begin
      r = REG_CNT;
    end else if (addr == mmioBase + MMIO_OFF_STAT) begin
      r = REG_STAT;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port bundle. The CPU drives the master side; the
// responder sits on the slave side and returns registered read data.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic                  dm_write;
  logic [31:0]           dm_addr;
  logic [DATA_WIDTH-1:0] dm_data_in;
  logic [DATA_WIDTH-1:0] dm_data_out;

  modport master (
    output dm_write,
    output dm_addr,
    output dm_data_in,
    input  dm_data_out
  );

  modport slave (
    input  dm_write,
    input  dm_addr,
    input  dm_data_in,
    output dm_data_out
  );

endinterface

// File: rtl/data_mem_responder_dm_ram.sv
// Single-port synchronous word RAM with read-first behaviour: a read of the
// word being written in the same cycle returns the old contents.
module dm_ram
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read the old word and optionally overwrite it on the same edge
  always_ff @(posedge clk) begin
    rdata_q <= mem[addr_i];
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port: word RAM plus a small MMIO
// window (GPIO output, free-running cycle counter, sticky error status).
// Read data is returned one cycle after the address is presented.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   dm,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [1:0]            watch_err
);

  localparam logic [31:0] RAM_BYTES = 32'd4 << ADDR_WIDTH;

  region_e               region;
  logic                  misaligned;
  logic                  writeOk;
  logic                  ramWe;
  logic [DATA_WIDTH-1:0] ramRdata;

  logic [DATA_WIDTH-1:0] gpio_q,     gpio_d;
  logic [31:0]           cnt_q,      cnt_d;
  logic [1:0]            status_q,   status_d;
  logic                  readRam_q,  readRam_d;
  logic [DATA_WIDTH-1:0] mmioData_q, mmioData_d;

  // Address decode; misaligned accesses never reach any region
  always_comb begin
    misaligned = (dm.dm_addr[1:0] != 2'b00);
    region     = decodeRegion(dm.dm_addr, RAM_BYTES, MMIO_BASE);
    writeOk    = dm.dm_write && !misaligned && !rst;
    ramWe      = writeOk && (region == REG_RAM);
  end

  dm_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ramWe),
    .addr_i  (dm.dm_addr[ADDR_WIDTH+1:2]),
    .wdata_i (dm.dm_data_in),
    .rdata_o (ramRdata)
  );

  // Next-state for the MMIO registers, status and the read-data selection
  always_comb begin
    gpio_d     = gpio_q;
    cnt_d      = cnt_q + 32'd1;
    status_d   = status_q;
    readRam_d  = !misaligned && (region == REG_RAM);
    mmioData_d = '0;

    if (writeOk && (region == REG_GPIO)) begin
      gpio_d = dm.dm_data_in;
    end

    if (writeOk && (region == REG_CNT)) begin
      cnt_d = dm.dm_data_in;
    end

    // Clear first so that a fresh error in the same cycle wins
    if (writeOk && (region == REG_STAT)) begin
      status_d = status_q & ~dm.dm_data_in[1:0];
    end
    if (misaligned) begin
      status_d[ERR_MISALIGNED] = 1'b1;
    end else if (region == REG_UNMAPPED) begin
      status_d[ERR_UNMAPPED] = 1'b1;
    end

    if (!misaligned) begin
      case (region)
        REG_GPIO: mmioData_d = gpio_q;
        REG_CNT:  mmioData_d = cnt_q;
        REG_STAT: mmioData_d = {30'b0, status_q};
        default:  mmioData_d = '0;
      endcase
    end
  end

  // Register update with synchronous reset; RAM contents are left alone
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q     <= '0;
      cnt_q      <= '0;
      status_q   <= 2'b00;
      readRam_q  <= 1'b0;
      mmioData_q <= '0;
    end else begin
      gpio_q     <= gpio_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      readRam_q  <= readRam_d;
      mmioData_q <= mmioData_d;
    end
  end

  assign dm.dm_data_out = readRam_q ? ramRdata : mmioData_q;
  assign gpio_out       = gpio_q;
  assign watch_err      = status_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a behavioural memory-map model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] gpio_out;
  logic [1:0]  watch_err;

  data_mem_responder_if dmIf ();

  data_mem_responder #(
    .ADDR_WIDTH (10),
    .MMIO_BASE  (32'h0000_8000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dm        (dmIf),
    .gpio_out  (gpio_out),
    .watch_err (watch_err)
  );

  int checks;
  int errors;

  // Model state
  logic [31:0] mRam [1024];
  bit          mKnown [1024];
  logic [31:0] mGpio;
  logic [31:0] mCnt;
  logic [1:0]  mStat;
  logic [31:0] expOut;
  bit          expOutKnown;
  bit          modelValid;

  logic [31:0] sAddr;
  logic [31:0] sData;
  bit          sWrite;
  logic [31:0] nCnt;
  logic [1:0]  nStat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-map model: expected state after each rising edge
  always @(posedge clk) begin
    sAddr  = dmIf.dm_addr;
    sData  = dmIf.dm_data_in;
    sWrite = dmIf.dm_write;
    if (rst) begin
      expOut      = 32'h0;
      expOutKnown = 1'b1;
      mGpio       = 32'h0;
      mCnt        = 32'h0;
      mStat       = 2'b00;
      modelValid  = 1'b1;
    end else begin
      nCnt        = mCnt + 32'd1;
      nStat       = mStat;
      expOutKnown = 1'b1;
      expOut      = 32'h0;
      if (sAddr % 4 != 0) begin
        nStat = nStat | 2'b01;
      end else if (sAddr < 32'd4096) begin
        expOutKnown = mKnown[sAddr/4];
        expOut      = mRam[sAddr/4];
        if (sWrite) begin
          mRam[sAddr/4]   = sData;
          mKnown[sAddr/4] = 1'b1;
        end
      end else if (sAddr == 32'h8000) begin
        expOut = mGpio;
        if (sWrite) mGpio = sData;
      end else if (sAddr == 32'h8004) begin
        expOut = mCnt;
        if (sWrite) nCnt = sData;
      end else if (sAddr == 32'h8008) begin
        expOut = {30'b0, mStat};
        if (sWrite) nStat = mStat & ~sData[1:0];
      end else begin
        nStat = nStat | 2'b10;
      end
      mCnt  = nCnt;
      mStat = nStat;
    end
  end

  // Compare DUT outputs with the model away from the active edge
  always @(negedge clk) begin
    if (modelValid) begin
      if (expOutKnown) begin
        checks++;
        if (dmIf.dm_data_out !== expOut) begin
          errors++;
          $display("[TB] FAIL model_data_out @%0t: got %h, expected %h", $time, dmIf.dm_data_out, expOut);
        end
      end
      checks++;
      if (gpio_out !== mGpio) begin
        errors++;
        $display("[TB] FAIL model_gpio @%0t: got %h, expected %h", $time, gpio_out, mGpio);
      end
      checks++;
      if (watch_err !== mStat) begin
        errors++;
        $display("[TB] FAIL model_watch_err @%0t: got %b, expected %b", $time, watch_err, mStat);
      end
    end
  end

  // Present one access for one cycle, return just after the edge
  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d);
    dmIf.dm_write   = w;
    dmIf.dm_addr    = a;
    dmIf.dm_data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Literal expectation check
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    modelValid = 1'b0;
    for (int i = 0; i < 1024; i++) mKnown[i] = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h8000, 32'h0);
    applyStimulus(1'b0, 32'h8000, 32'h0);
    checkOutput("reset_data_out", dmIf.dm_data_out, 32'h0);
    checkOutput("reset_gpio", gpio_out, 32'h0);
    checkOutput("reset_watch_err", {30'b0, watch_err}, 32'h0);

    // Counter: five idle cycles then read
    rst = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h8000, 32'h0);
    applyStimulus(1'b0, 32'h8004, 32'h0);
    checkOutput("cnt_after_5", dmIf.dm_data_out, 32'd5);
    applyStimulus(1'b1, 32'h8004, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 32'h8004, 32'h0);
    checkOutput("cnt_loaded", dmIf.dm_data_out, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 32'h8004, 32'h0);
    checkOutput("cnt_max", dmIf.dm_data_out, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 32'h8004, 32'h0);
    checkOutput("cnt_wrap", dmIf.dm_data_out, 32'h0);

    // RAM round trip with read-first
    applyStimulus(1'b1, 32'h10, 32'h1111_1111);
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF);
    checkOutput("ram_read_first", dmIf.dm_data_out, 32'h1111_1111);
    applyStimulus(1'b0, 32'h10, 32'h0);
    checkOutput("ram_roundtrip", dmIf.dm_data_out, 32'hDEAD_BEEF);

    // GPIO write, read back, then reset during a write
    applyStimulus(1'b1, 32'h8000, 32'h0000_00A5);
    checkOutput("gpio_written", gpio_out, 32'h0000_00A5);
    applyStimulus(1'b0, 32'h8000, 32'h0);
    checkOutput("gpio_readback", dmIf.dm_data_out, 32'h0000_00A5);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h8000, 32'h0000_0055);
    checkOutput("gpio_after_rst", gpio_out, 32'h0);
    checkOutput("data_out_after_rst", dmIf.dm_data_out, 32'h0);
    rst = 1'b0;

    // Misaligned write leaves RAM alone and sets bit0
    applyStimulus(1'b1, 32'h12, 32'h0000_1234);
    checkOutput("misaligned_wr_out", dmIf.dm_data_out, 32'h0);
    checkOutput("misaligned_err", {30'b0, watch_err}, 32'h1);
    applyStimulus(1'b0, 32'h10, 32'h0);
    checkOutput("ram_unchanged", dmIf.dm_data_out, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h12, 32'h0);
    checkOutput("misaligned_rd", dmIf.dm_data_out, 32'h0);

    // Unmapped read and STAT clearing
    applyStimulus(1'b0, 32'h9000, 32'h0);
    checkOutput("unmapped_rd", dmIf.dm_data_out, 32'h0);
    checkOutput("unmapped_err", {30'b0, watch_err}, 32'h3);
    applyStimulus(1'b1, 32'h8008, 32'h3);
    checkOutput("stat_read_pre", dmIf.dm_data_out, 32'h3);
    checkOutput("stat_cleared", {30'b0, watch_err}, 32'h0);

    // Misaligned W1C to STAT sets bit0 and clears nothing
    applyStimulus(1'b0, 32'h9000, 32'h0);
    applyStimulus(1'b1, 32'h800A, 32'h3);
    checkOutput("stat_mis_w1c", {30'b0, watch_err}, 32'h3);
    applyStimulus(1'b1, 32'h8008, 32'h2);
    checkOutput("stat_clear_bit1", {30'b0, watch_err}, 32'h1);
    applyStimulus(1'b1, 32'h8008, 32'h1);
    checkOutput("stat_clear_bit0", {30'b0, watch_err}, 32'h0);

    // Last RAM word and first address past RAM
    applyStimulus(1'b1, 32'hFFC, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'hFFC, 32'h0);
    checkOutput("ram_last_word", dmIf.dm_data_out, 32'hCAFE_F00D);
    checkOutput("ram_last_err", {30'b0, watch_err}, 32'h0);
    applyStimulus(1'b1, 32'h1000, 32'h7777_7777);
    checkOutput("past_ram_rd", dmIf.dm_data_out, 32'h0);
    checkOutput("past_ram_err", {30'b0, watch_err}, 32'h2);
    applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h8000, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
